fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_if_id_reg.sv | 78 +++++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM encoding, default
// constants, the opcodes decode looks at, and a PC alignment helper.
package fetch_stage_pkg;

  // Fetch FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  // Default PC after reset and the bubble word (addi x0,x0,0)
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // RV32I major opcodes consumed by decode
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Instruction addresses are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with a one-entry hold buffer. A response that
// arrives while decode is stalled parks in the hold buffer; the buffer
// drains into IF/ID as soon as IF/ID becomes loadable again.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_pc_i,
  input  logic [31:0] resp_instr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        hold_full_o
);

  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic        r_hold_valid;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic        w_loadable;

  // An empty IF/ID can always accept; a full one only when decode moves on
  assign w_loadable = !r_id_valid || !stall_i;

  // IF/ID and hold buffer update: flush wins, then drain hold, then new data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_id_valid   <= 1'b0;
      r_id_pc      <= 32'h0;
      r_id_instr   <= NOP_INSTR;
      r_hold_valid <= 1'b0;
      r_hold_pc    <= 32'h0;
      r_hold_instr <= NOP_INSTR;
    end else if (flush_i) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= NOP_INSTR;
      r_hold_valid <= 1'b0;
    end else if (w_loadable) begin
      if (r_hold_valid) begin
        // Oldest instruction goes first; a simultaneous response (not
        // expected, since fetch stops while the buffer is full) refills it.
        r_id_valid   <= 1'b1;
        r_id_pc      <= r_hold_pc;
        r_id_instr   <= r_hold_instr;
        r_hold_valid <= resp_valid_i;
        if (resp_valid_i) begin
          r_hold_pc    <= resp_pc_i;
          r_hold_instr <= resp_instr_i;
        end
      end else if (resp_valid_i) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= resp_pc_i;
        r_id_instr <= resp_instr_i;
      end else begin
        r_id_valid <= 1'b0;
        r_id_instr <= NOP_INSTR;
      end
    end else if (resp_valid_i) begin
      r_hold_valid <= 1'b1;
      r_hold_pc    <= resp_pc_i;
      r_hold_instr <= resp_instr_i;
    end
  end

  assign id_valid_o  = r_id_valid;
  assign id_pc_o     = r_id_pc;
  assign id_instr_o  = r_id_valid ? r_id_instr : NOP_INSTR;
  assign hold_full_o = r_hold_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/gnt/rvalid handshake
// to instruction memory and feeds the IF/ID register towards decode.
// At most one request is outstanding; a flushed request is drained.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_fetch_pc;
  logic         w_req;
  logic         w_accept;
  logic         w_deliver;
  logic         w_hold_full;

  // Next-state, PC and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_req        = 1'b0;
    w_accept     = 1'b0;
    w_deliver    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        // No new request while a stalled response is parked
        w_req = !w_hold_full;
        if (w_req && imem_gnt_i) begin
          w_accept = 1'b1;
          if (flush_i) begin
            w_state_next = ST_DRAIN;
          end else begin
            w_state_next = ST_WAIT;
            w_pc_next    = r_pc + 32'd4;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          w_state_next = ST_FETCH;
          w_deliver    = !flush_i;
        end else if (flush_i) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Swallow the response of a request that a flush made stale
        if (imem_rvalid_i) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
    // A redirect overrides any sequential PC update in every state
    if (flush_i) w_pc_next = word_align(redirect_pc_i);
  end

  // FSM state and PC registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Remember the address of the granted request so its response carries it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_accept) begin
      r_fetch_pc <= r_pc;
    end
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;

  fetch_stage_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .resp_valid_i (w_deliver),
    .resp_pc_i    (r_fetch_pc),
    .resp_instr_i (imem_rdata_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_instr_o   (id_instr_o),
    .hold_full_o  (w_hold_full)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle table drives the memory and
// hazard inputs and lists the outputs expected in that cycle, followed by
// hand-written sequences for reset during an outstanding fetch.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fetch_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o)
  );

  typedef struct {
    logic        start;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic g, input logic rv,
                              input logic [31:0] rd, input logic sl,
                              input logic fl, input logic [31:0] rp,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei);
    vec_t v;
    v.start = st; v.gnt = g; v.rv = rv; v.rdata = rd; v.stall = sl;
    v.flush = fl; v.rpc = rp; v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic e_req,
                             input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_pc, input logic [31:0] e_instr);
    chk("imem_req", idx, {31'd0, imem_req_o}, {31'd0, e_req});
    chk("imem_addr", idx, imem_addr_o, e_addr);
    chk("id_valid", idx, {31'd0, id_valid_o}, {31'd0, e_valid});
    chk("id_instr", idx, id_instr_o, e_instr);
    if (e_valid) chk("id_pc", idx, id_pc_o, e_pc);
  endtask

  initial begin
    //              st g  rv rdata          sl fl rpc            req addr           v  pc             instr
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         NOP);
    vecs[1]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         NOP);
    vecs[2]  = mk(0, 0, 1, 32'h00500093,  0, 0, 32'h0,         0, 32'h4,         0, 32'h0,         NOP);
    vecs[3]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4,         1, 32'h0,         32'h00500093);
    vecs[4]  = mk(0, 0, 1, 32'h00100113,  0, 0, 32'h0,         0, 32'h8,         0, 32'h0,         NOP);
    vecs[5]  = mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         1, 32'h4,         32'h00100113);
    vecs[6]  = mk(0, 0, 1, 32'h00200193,  1, 0, 32'h0,         0, 32'hC,         1, 32'h4,         32'h00100113);
    vecs[7]  = mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         1, 32'h4,         32'h00100113);
    vecs[8]  = mk(0, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         1, 32'h4,         32'h00100113);
    vecs[9]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hC,         1, 32'h4,         32'h00100113);
    vecs[10] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         1, 32'h8,         32'h00200193);
    vecs[11] = mk(0, 0, 1, 32'h00300213,  0, 0, 32'h0,         0, 32'h10,        0, 32'h0,         NOP);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        1, 32'hC,         32'h00300213);
    vecs[13] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        0, 32'h0,         NOP);
    vecs[14] = mk(0, 0, 0, 32'h0,         0, 1, 32'h100,       0, 32'h14,        0, 32'h0,         NOP);
    vecs[15] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         NOP);
    vecs[16] = mk(0, 0, 1, 32'hDEADBEEF,  0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         NOP);
    vecs[17] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         NOP);
    vecs[18] = mk(0, 0, 1, 32'h00400293,  0, 1, 32'h203,       0, 32'h104,       0, 32'h0,         NOP);
    vecs[19] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         NOP);
    vecs[20] = mk(0, 0, 1, 32'h00500313,  0, 0, 32'h0,         0, 32'h204,       0, 32'h0,         NOP);
    vecs[21] = mk(0, 0, 0, 32'h0,         1, 1, 32'h300,       1, 32'h204,       1, 32'h200,       32'h00500313);
    vecs[22] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h300,       0, 32'h0,         NOP);
    vecs[23] = mk(0, 1, 0, 32'h0,         0, 1, 32'h400,       1, 32'h300,       0, 32'h0,         NOP);
    vecs[24] = mk(0, 0, 1, 32'h00000BAD,  0, 0, 32'h0,         0, 32'h400,       0, 32'h0,         NOP);
    vecs[25] = mk(0, 0, 0, 32'h0,         0, 1, 32'hFFFFFFFC,  1, 32'h400,       0, 32'h0,         NOP);
    vecs[26] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,         NOP);
    vecs[27] = mk(0, 0, 1, 32'h00600393,  0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         NOP);
    vecs[28] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         1, 32'hFFFFFFFC,  32'h00600393);

    rst_i = 1'b0; start_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;

    repeat (3) @(negedge clk_i);
    chk_outputs(-1, 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    chk("reset_id_pc", -1, id_pc_o, 32'h0);
    rst_i = 1'b1;

    // Cycle table: outputs reflect the previous edge, inputs feed the next
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      chk_outputs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                  vecs[i].e_pc, vecs[i].e_instr);
      start_i       = vecs[i].start;
      imem_gnt_i    = vecs[i].gnt;
      imem_rvalid_i = vecs[i].rv;
      imem_rdata_i  = vecs[i].rdata;
      stall_i       = vecs[i].stall;
      flush_i       = vecs[i].flush;
      redirect_pc_i = vecs[i].rpc;
    end

    // Reset asserted while a request is outstanding in WAIT
    @(negedge clk_i);
    start_i = 1'b0; imem_rvalid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    imem_gnt_i = 1'b1;
    @(negedge clk_i);
    imem_gnt_i = 1'b0;
    chk("wait_req", 100, {31'd0, imem_req_o}, 32'd0);
    chk("wait_addr", 100, imem_addr_o, 32'h4);
    #2 rst_i = 1'b0;
    #1;
    chk_outputs(101, 1'b0, 32'h0, 1'b0, 32'h0, NOP);
    chk("async_rst_id_pc", 101, id_pc_o, 32'h0);

    // Late rvalid of the aborted request must be ignored in IDLE
    @(negedge clk_i);
    rst_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEADBEEF;
    @(negedge clk_i);
    imem_rvalid_i = 1'b0;
    chk_outputs(102, 1'b0, 32'h0, 1'b0, 32'h0, NOP);

    // Restart fetches from the reset PC
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk_outputs(103, 1'b1, 32'h0, 1'b0, 32'h0, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
